mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single main-memory read/write port between three requesters: dcache write, dcache read and icache read.
- Sits between the core's cache miss/write-through interfaces and the data memory.
- Serves one transaction at a time with fixed priority, plus an anti-starvation counter that guarantees the icache is served.
- Registers and returns the cache line or write acknowledge to the granted requester.

Parameters:
- DATA_WIDTH, 64, write data width.
- ADDR_WIDTH, 64, address width.
- CACHE_LINE_WIDTH, 256, read line width.
- STARVE_LIMIT, 4, consecutive dcache grants tolerated while an icache request is pending.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_dcache_write_valid  in  1  dcache write request (level).
- i_dcache_write_address  in  ADDR_WIDTH  write byte address.
- i_dcache_write_data  in  DATA_WIDTH  write data.
- i_dcache_write_strobe  in  DATA_WIDTH/8  byte enables.
- o_dcache_write_done  out  1  one-cycle write-complete pulse.
- i_dcache_read_req  in  1  dcache line read request (level).
- i_dcache_read_address  in  ADDR_WIDTH  read address.
- o_dcache_cache_line  out  CACHE_LINE_WIDTH  returned line.
- o_dcache_read_done  out  1  one-cycle read-complete pulse.
- i_icache_read_req  in  1  icache line read request (level).
- i_icache_read_address  in  ADDR_WIDTH  read address.
- o_icache_cache_line  out  CACHE_LINE_WIDTH  returned line.
- o_icache_read_done  out  1  one-cycle read-complete pulse.
- o_mem_read_req  out  1  memory read request (level).
- o_mem_read_address  out  ADDR_WIDTH  line-aligned read address.
- i_mem_read_done  in  1  memory read complete.
- i_cache_line  in  CACHE_LINE_WIDTH  memory read data, valid with i_mem_read_done.
- o_mem_write_valid  out  1  memory write request (level).
- o_mem_write_address  out  ADDR_WIDTH  write address.
- o_mem_write_data  out  DATA_WIDTH  write data.
- o_write_strobe  out  DATA_WIDTH/8  byte enables.
- i_mem_write_done  in  1  memory write complete.

Behaviour:
- Reset: one clock; synchronous active-low reset i_rst_n sampled on the rising edge of i_clk.
  - On reset, all outputs go to 0, the state goes to IDLE, and the starvation counter is cleared.
  - Reset mid-transaction abandons the transaction: the memory request drops the next cycle and no done pulse is issued.
- States: IDLE, WR, RD_D, RD_I, RESP.
- IDLE: arbitrate among the requests sampled this cycle.
  - Default priority: dcache write > dcache read > icache read.
  - If icache is pending and starve_cnt == STARVE_LIMIT, grant icache regardless of the others.
  - On grant, latch the requester id, the address (and data/strobe for a write) into holding registers, and move to WR / RD_D / RD_I.
  - No request: stay in IDLE.
- WR: o_mem_write_valid = 1 with the latched address/data/strobe; hold until i_mem_write_done, then go to RESP.
- RD_D / RD_I: o_mem_read_req = 1.
  - o_mem_read_address = latched address with bits [log2(CACHE_LINE_WIDTH/8)-1:0] forced to 0.
  - On i_mem_read_done, capture i_cache_line into the granted requester's line register, then go to RESP.
- RESP: assert exactly one of o_dcache_write_done / o_dcache_read_done / o_icache_read_done for this single cycle, then return to IDLE.
  - No arbitration happens in RESP, so a requester that drops its request on seeing done is never re-granted.
- Latency:
  - Grant to memory request: 1 cycle (the request is registered out of IDLE).
  - Memory done to requester done: 1 cycle.
  - Minimum turnaround for a 1-cycle memory: 4 cycles per transaction.
- Line registers hold their value until the next capture for that requester; they are valid at least in the cycle the matching done pulse is high.
- Memory outputs:
  - o_mem_read_req and o_mem_write_valid are never high together.
  - Both drop in the cycle after the done input is seen.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, on each dcache grant made while i_icache_read_req is high.
  - Clears on any icache grant.
  - Holds when a dcache grant is made with no icache request.
- Requester inputs change while not granted: ignored; only values sampled at grant are used.
- Done inputs arriving in IDLE/RESP, or the done input of the other channel: ignored.
- Simultaneous requests in the same cycle: resolved strictly by the priority rule; losers stay pending, since requesters hold their request level until their own done.

Test Plan:
1. Icache read only, address 0x1008; memory returns done 3 cycles after request with line 0xA5..A5 -> o_mem_read_address = 0x1000, o_icache_cache_line = 0xA5..A5, o_icache_read_done one cycle wide, 1 cycle after i_mem_read_done.
2. dcache write (address 0x40, data 0x1122334455667788, strobe 0xF0) and dcache read (0x80) in the same cycle -> write served first with exact address/data/strobe, then the read; o_mem_read_req and o_mem_write_valid never overlap.
3. icache held high while dcache read is re-requested every cycle, STARVE_LIMIT = 4 -> after 4 dcache grants the 5th grant goes to icache; the counter then clears.
4. Reset asserted while in RD_D waiting for done -> next cycle all outputs 0, state IDLE, no o_dcache_read_done; a subsequent request is served normally.
5. Requester holds its request through the RESP cycle and drops it on seeing done -> exactly one memory transaction and one done pulse; no duplicate grant.
6. Spurious i_mem_write_done during a read, and i_mem_read_done in IDLE -> no state change, no done pulse.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the shared main-memory port.
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH       = 64,
    parameter int ADDR_WIDTH       = 64,
    parameter int CACHE_LINE_WIDTH = 256
);
    // Handshake: every request (valid/req) is a level held by its owner until the
    // matching *_done; every *_done is a single-cycle completion pulse.
    logic                          dcache_write_valid;
    logic [ADDR_WIDTH-1:0]         dcache_write_address;
    logic [DATA_WIDTH-1:0]         dcache_write_data;
    logic [DATA_WIDTH/8-1:0]       dcache_write_strobe;
    logic                          dcache_write_done;
    logic                          dcache_read_req;
    logic [ADDR_WIDTH-1:0]         dcache_read_address;
    logic [CACHE_LINE_WIDTH-1:0]   dcache_cache_line;
    logic                          dcache_read_done;
    logic                          icache_read_req;
    logic [ADDR_WIDTH-1:0]         icache_read_address;
    logic [CACHE_LINE_WIDTH-1:0]   icache_cache_line;
    logic                          icache_read_done;
    logic                          mem_read_req;
    logic [ADDR_WIDTH-1:0]         mem_read_address;
    logic                          mem_read_done;
    logic [CACHE_LINE_WIDTH-1:0]   cache_line;
    logic                          mem_write_valid;
    logic [ADDR_WIDTH-1:0]         mem_write_address;
    logic [DATA_WIDTH-1:0]         mem_write_data;
    logic [DATA_WIDTH/8-1:0]       write_strobe;
    logic                          mem_write_done;

    modport master (
        input  dcache_write_valid, dcache_write_address, dcache_write_data, dcache_write_strobe,
        input  dcache_read_req, dcache_read_address, icache_read_req, icache_read_address,
        input  mem_read_done, cache_line, mem_write_done,
        output dcache_write_done, dcache_cache_line, dcache_read_done,
        output icache_cache_line, icache_read_done,
        output mem_read_req, mem_read_address,
        output mem_write_valid, mem_write_address, mem_write_data, write_strobe
    );

    modport slave (
        output dcache_write_valid, dcache_write_address, dcache_write_data, dcache_write_strobe,
        output dcache_read_req, dcache_read_address, icache_read_req, icache_read_address,
        output mem_read_done, cache_line, mem_write_done,
        input  dcache_write_done, dcache_cache_line, dcache_read_done,
        input  icache_cache_line, icache_read_done,
        input  mem_read_req, mem_read_address,
        input  mem_write_valid, mem_write_address, mem_write_data, write_strobe
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter sharing one memory port between dcache write, dcache read
// and icache read, with a starvation counter that forces an icache grant.
module mem_port_arbiter #(
    parameter int DATA_WIDTH       = 64,
    parameter int ADDR_WIDTH       = 64,
    parameter int CACHE_LINE_WIDTH = 256,
    parameter int STARVE_LIMIT     = 4,
    localparam int CNT_W           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    mem_port_arbiter_if.master   bus,
    output logic [2:0]           state_dbg,
    output logic [CNT_W-1:0]     starve_cnt_dbg
);
    localparam int LINE_OFF = $clog2(CACHE_LINE_WIDTH / 8);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] WR   = 3'd1;
    localparam logic [2:0] RD_D = 3'd2;
    localparam logic [2:0] RD_I = 3'd3;
    localparam logic [2:0] RESP = 3'd4;

    localparam logic [1:0] ID_WR   = 2'd0;
    localparam logic [1:0] ID_RD_D = 2'd1;
    localparam logic [1:0] ID_RD_I = 2'd2;

    logic [2:0]                  state;
    logic [CNT_W-1:0]            starve_cnt;
    logic [ADDR_WIDTH-1:0]       addr_q;
    logic [DATA_WIDTH-1:0]       data_q;
    logic [DATA_WIDTH/8-1:0]     strobe_q;
    logic                        mem_read_req_q;
    logic                        mem_write_valid_q;
    logic [CACHE_LINE_WIDTH-1:0] dline_q;
    logic [CACHE_LINE_WIDTH-1:0] iline_q;
    logic                        wr_done_q;
    logic                        drd_done_q;
    logic                        ird_done_q;

    logic                        grant_valid;
    logic [1:0]                  grant_sel;

    // A saturated counter with icache pending overrides the normal priority order.
    always_comb begin
        grant_valid = 1'b1;
        grant_sel   = ID_WR;
        if (bus.icache_read_req && starve_cnt == CNT_W'(STARVE_LIMIT)) begin
            grant_sel = ID_RD_I;
        end else if (bus.dcache_write_valid) begin
            grant_sel = ID_WR;
        end else if (bus.dcache_read_req) begin
            grant_sel = ID_RD_D;
        end else if (bus.icache_read_req) begin
            grant_sel = ID_RD_I;
        end else begin
            grant_valid = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state             <= IDLE;
            starve_cnt        <= '0;
            addr_q            <= '0;
            data_q            <= '0;
            strobe_q          <= '0;
            mem_read_req_q    <= 1'b0;
            mem_write_valid_q <= 1'b0;
            dline_q           <= '0;
            iline_q           <= '0;
            wr_done_q         <= 1'b0;
            drd_done_q        <= 1'b0;
            ird_done_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        unique case (grant_sel)
                            ID_WR: begin
                                addr_q            <= bus.dcache_write_address;
                                data_q            <= bus.dcache_write_data;
                                strobe_q          <= bus.dcache_write_strobe;
                                mem_write_valid_q <= 1'b1;
                                state             <= WR;
                            end
                            ID_RD_D: begin
                                addr_q         <= bus.dcache_read_address;
                                mem_read_req_q <= 1'b1;
                                state          <= RD_D;
                            end
                            default: begin
                                addr_q         <= bus.icache_read_address;
                                mem_read_req_q <= 1'b1;
                                state          <= RD_I;
                            end
                        endcase
                        if (grant_sel == ID_RD_I) begin
                            starve_cnt <= '0;
                        end else if (bus.icache_read_req && starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                            starve_cnt <= starve_cnt + CNT_W'(1);
                        end
                    end
                end
                WR: begin
                    if (bus.mem_write_done) begin
                        mem_write_valid_q <= 1'b0;
                        wr_done_q         <= 1'b1;
                        state             <= RESP;
                    end
                end
                RD_D: begin
                    if (bus.mem_read_done) begin
                        mem_read_req_q <= 1'b0;
                        dline_q        <= bus.cache_line;
                        drd_done_q     <= 1'b1;
                        state          <= RESP;
                    end
                end
                RD_I: begin
                    if (bus.mem_read_done) begin
                        mem_read_req_q <= 1'b0;
                        iline_q        <= bus.cache_line;
                        ird_done_q     <= 1'b1;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    // Requests are ignored here so a requester dropping on done is never re-granted.
                    wr_done_q  <= 1'b0;
                    drd_done_q <= 1'b0;
                    ird_done_q <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_read_req      = mem_read_req_q;
    assign bus.mem_read_address  = {addr_q[ADDR_WIDTH-1:LINE_OFF], {LINE_OFF{1'b0}}};
    assign bus.mem_write_valid   = mem_write_valid_q;
    assign bus.mem_write_address = addr_q;
    assign bus.mem_write_data    = data_q;
    assign bus.write_strobe      = strobe_q;
    assign bus.dcache_cache_line = dline_q;
    assign bus.icache_cache_line = iline_q;
    assign bus.dcache_write_done = wr_done_q;
    assign bus.dcache_read_done  = drd_done_q;
    assign bus.icache_read_done  = ird_done_q;
    assign state_dbg             = state;
    assign starve_cnt_dbg        = starve_cnt;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: requesters and a memory responder driven each cycle, checked
// against a transaction-timeline reference model of the arbiter.
module tb_mem_port_arbiter;
    localparam int DW    = 64;
    localparam int AW    = 64;
    localparam int LW    = 256;
    localparam int LIMIT = 4;
    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam int NCYC  = 3000;

    localparam int PH_IDLE = 0;
    localparam int PH_BUSY = 1;
    localparam int PH_RESP = 2;
    localparam int PH_RST  = 3;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]       state_dbg;
    logic [CNT_W-1:0] starve_cnt_dbg;

    mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CACHE_LINE_WIDTH(LW)) bus ();

    mem_port_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CACHE_LINE_WIDTH(LW), .STARVE_LIMIT(LIMIT)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .bus            (bus),
        .state_dbg      (state_dbg),
        .starve_cnt_dbg (starve_cnt_dbg)
    );

    int checks = 0;
    int errors = 0;

    // scoreboard: lines returned by memory, awaiting the requester done pulse
    logic [LW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // winner for a pending vector {icache, dread, dwrite} and a starvation count
    function automatic int pick(input bit [2:0] pend, input int c);
        if (pend[2] && c == LIMIT) return 2;
        for (int i = 0; i < 3; i++) if (pend[i]) return i;
        return -1;
    endfunction

    // requester and memory model state
    bit            req_on [3];
    logic [AW-1:0] req_addr [3];
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    int            phase = PH_IDLE;
    int            cur_id = 0;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_data;
    logic [DW/8-1:0] cur_strb;
    int            cnt = 0;
    int            lat = 0;
    logic [LW-1:0] m_dline = '0;
    logic [LW-1:0] m_iline = '0;
    bit            done_drv = 0;
    bit            rst_drv = 1;
    bit            want_reset = 0;
    bit            idle_known = 0;
    logic [2:0]    idle_code = '0;

    task automatic drive_requesters();
        bus.dcache_write_valid   = req_on[0];
        bus.dcache_write_address = req_addr[0];
        bus.dcache_write_data    = wdata;
        bus.dcache_write_strobe  = wstrb;
        bus.dcache_read_req      = req_on[1];
        bus.dcache_read_address  = req_addr[1];
        bus.icache_read_req      = req_on[2];
        bus.icache_read_address  = req_addr[2];
    endtask

    task automatic check_outputs();
        logic [2:0] dones;
        logic [LW-1:0] line;
        dones = {bus.icache_read_done, bus.dcache_read_done, bus.dcache_write_done};
        check("no_overlap", LW'(bus.mem_read_req & bus.mem_write_valid), '0);
        case (phase)
            PH_RST: begin
                if (!idle_known) begin
                    idle_code  = state_dbg;
                    idle_known = 1;
                end else begin
                    check("rst_state", LW'(state_dbg), LW'(idle_code));
                end
                check("rst_rd_req", LW'(bus.mem_read_req), '0);
                check("rst_wr_valid", LW'(bus.mem_write_valid), '0);
                check("rst_rd_addr", LW'(bus.mem_read_address), '0);
                check("rst_wr_addr", LW'(bus.mem_write_address), '0);
                check("rst_wr_data", LW'(bus.mem_write_data), '0);
                check("rst_strobe", LW'(bus.write_strobe), '0);
                check("rst_dones", LW'(dones), '0);
            end
            PH_IDLE: begin
                check("idle_state", LW'(state_dbg), LW'(idle_code));
                check("idle_rd_req", LW'(bus.mem_read_req), '0);
                check("idle_wr_valid", LW'(bus.mem_write_valid), '0);
                check("idle_dones", LW'(dones), '0);
            end
            PH_BUSY: begin
                check("busy_state", LW'(state_dbg != idle_code), LW'(1'b1));
                check("busy_rd_req", LW'(bus.mem_read_req), LW'(cur_id != 0));
                check("busy_wr_valid", LW'(bus.mem_write_valid), LW'(cur_id == 0));
                check("busy_dones", LW'(dones), '0);
                if (cur_id == 0) begin
                    check("wr_addr", LW'(bus.mem_write_address), LW'(cur_addr));
                    check("wr_data", LW'(bus.mem_write_data), LW'(cur_data));
                    check("wr_strobe", LW'(bus.write_strobe), LW'(cur_strb));
                end else begin
                    check("rd_addr", LW'(bus.mem_read_address), LW'(cur_addr & ~AW'(LW / 8 - 1)));
                end
            end
            default: begin
                check("resp_rd_req", LW'(bus.mem_read_req), '0);
                check("resp_wr_valid", LW'(bus.mem_write_valid), '0);
                check("resp_done", LW'(dones), LW'(3'b001 << cur_id));
                if (cur_id != 0 && exp_q.size() > 0) begin
                    line = exp_q.pop_front();
                    if (cur_id == 1) m_dline = line;
                    else m_iline = line;
                end
            end
        endcase
        check("dline", bus.dcache_cache_line, m_dline);
        check("iline", bus.icache_cache_line, m_iline);
        check("starve_cnt", LW'(starve_cnt_dbg), LW'(cnt));
    endtask

    initial begin
        bit [2:0] pend;
        int w;
        int load;
        for (int i = 0; i < 3; i++) begin
            req_on[i]   = 0;
            req_addr[i] = '0;
        end
        wdata = '0;
        wstrb = '0;
        rst_n = 1'b0;
        bus.mem_read_done  = 1'b0;
        bus.mem_write_done = 1'b0;
        bus.cache_line     = '0;
        drive_requesters();

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            // advance the transaction timeline using what was driven before the last edge
            pend = {req_on[2], req_on[1], req_on[0]};
            if (rst_drv) begin
                phase   = PH_RST;
                cnt     = 0;
                m_dline = '0;
                m_iline = '0;
                exp_q.delete();
            end else if (phase == PH_IDLE || phase == PH_RST) begin
                w = pick(pend, cnt);
                if (w >= 0) begin
                    phase    = PH_BUSY;
                    cur_id   = w;
                    cur_addr = req_addr[w];
                    cur_data = wdata;
                    cur_strb = wstrb;
                    if (w == 2) cnt = 0;
                    else if (pend[2] && cnt < LIMIT) cnt++;
                    lat = $urandom_range(0, 3);
                end
            end else if (phase == PH_BUSY) begin
                if (done_drv) phase = PH_RESP;
            end else begin
                phase = PH_IDLE;
            end

            check_outputs();

            // reset, sometimes in the middle of a read waiting for memory
            done_drv = 0;
            rst_drv  = 0;
            bus.mem_read_done  = 1'b0;
            bus.mem_write_done = 1'b0;
            if (cyc % 350 == 349) want_reset = 1;
            if (want_reset && phase == PH_BUSY && cur_id != 0 && lat > 0) begin
                rst_drv    = 1;
                want_reset = 0;
            end
            rst_n = !rst_drv;

            // memory responder, with spurious done pulses on the wrong channel
            if (phase == PH_BUSY && !rst_drv) begin
                if (lat == 0) begin
                    bus.cache_line = rand_line();
                    if (cur_id == 0) bus.mem_write_done = 1'b1;
                    else begin
                        bus.mem_read_done = 1'b1;
                        exp_q.push_back(bus.cache_line);
                    end
                    done_drv = 1;
                end else begin
                    lat--;
                    if ($urandom_range(0, 3) == 0) begin
                        bus.cache_line = rand_line();
                        if (cur_id == 0) bus.mem_read_done = 1'b1;
                        else bus.mem_write_done = 1'b1;
                    end
                end
            end else if (phase != PH_BUSY && $urandom_range(0, 3) == 0) begin
                bus.cache_line = rand_line();
                if ($urandom_range(0, 1) == 0) bus.mem_read_done = 1'b1;
                else bus.mem_write_done = 1'b1;
            end

            // requesters: drop on own done, otherwise raise randomly and hold
            if (phase == PH_RESP) req_on[cur_id] = 0;
            load = (cyc >= 1000 && cyc < 1800) ? 95 : 30;
            for (int i = 0; i < 3; i++) begin
                if (!req_on[i] && !(phase == PH_RESP && i == cur_id)
                    && $urandom_range(0, 99) < load) begin
                    req_on[i]   = 1;
                    req_addr[i] = {$urandom, $urandom};
                    if (i == 0) begin
                        wdata = {$urandom, $urandom};
                        wstrb = DW'($urandom) >> (DW - DW / 8);
                    end
                end else if (!req_on[i]) begin
                    req_addr[i] = {$urandom, $urandom};
                end
            end
            if (phase == PH_BUSY && !done_drv) begin
                // granted requester's fields must no longer matter
                req_addr[cur_id] = {$urandom, $urandom};
                if (cur_id == 0) wdata = {$urandom, $urandom};
            end
            drive_requesters();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
